// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: CPU register map, LED channel
// addresses, CTRL bit positions, FSM state encoding and the ramp step helper.
package led_seq_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  // CPU register byte addresses
  localparam logic [ADDR_W-1:0] REG_TARGET0 = 5'd0;
  localparam logic [ADDR_W-1:0] REG_TARGET1 = 5'd4;
  localparam logic [ADDR_W-1:0] REG_TARGET2 = 5'd8;
  localparam logic [ADDR_W-1:0] REG_CTRL    = 5'd12;
  localparam logic [ADDR_W-1:0] REG_PERIOD  = 5'd16;

  // LED PWM peripheral channel addresses
  localparam logic [ADDR_W-1:0] LED_CH0_ADDR = 5'd0;
  localparam logic [ADDR_W-1:0] LED_CH1_ADDR = 5'd4;
  localparam logic [ADDR_W-1:0] LED_CH2_ADDR = 5'd8;

  // CTRL register bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_BREATHE_BIT = 1;

  // One cycle per channel update, then back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CH0  = 2'd1,
    ST_CH1  = 2'd2,
    ST_CH2  = 2'd3
  } state_t;

  // One saturating step of cur toward tgt; equal values stay put
  function automatic logic [DATA_W-1:0] ramp_step(input logic [DATA_W-1:0] cur,
                                                  input logic [DATA_W-1:0] tgt);
    logic [DATA_W-1:0] res;
    res = cur;
    if (cur < tgt)      res = cur + 8'd1;
    else if (cur > tgt) res = cur - 8'd1;
    return res;
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// Prescaler for the LED sequencer. A 16-bit counter runs while enabled and
// pulses tick for one cycle when it reaches {period, 8'hFF}, then reloads 0.
// While disabled the counter is held at 0, so re-enabling always restarts a
// full interval.
module led_seq_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] period,
  output logic       tick
);

  logic [15:0] r_cnt;
  logic        w_terminal;

  assign w_terminal = (r_cnt == {period, 8'hFF});
  assign tick       = enable && w_terminal;

  // Count while enabled, reload at terminal count, hold at 0 when disabled
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_cnt <= '0;
    end else if (w_terminal) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/led_seq.sv
// LED sequencer top. A CPU register file holds three channel targets, CTRL
// and PERIOD. Every prescaler tick starts a three-cycle burst that steps each
// channel's current duty one count toward its target and writes the new duty
// to the LED PWM peripheral.
// Optional feature: define LED_SEQ_BREATHE_EN to add breathe mode (CTRL bit1),
// where each channel bounces between its target (floor) and 255.
// Handshake: rd_en/wr_en are single-cycle strobes with no backpressure; read
// data appears with rd_valid exactly one cycle after rd_en, and m_wr_en is a
// fire-and-forget strobe qualifying m_addr/m_wr_data in the same cycle.
module led_seq
  import led_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wr_data,
  output logic              busy
);

  // Register file
  logic [DATA_W-1:0] r_target [0:2];
  logic              r_enable;
  logic [DATA_W-1:0] r_period;
`ifdef LED_SEQ_BREATHE_EN
  logic              r_breathe;
  logic              r_dir [0:2];   // 0 = up, 1 = down
  logic              w_dir_sel;
  logic              w_new_dir;
`endif

  // Channel state and CPU read path
  logic [DATA_W-1:0] r_cur [0:2];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] w_rd_mux;
  logic [DATA_W-1:0] w_ctrl_rd;

  // FSM and datapath
  state_t            r_state;
  state_t            w_next_state;
  logic              w_tick;
  logic [1:0]        w_ch_idx;
  logic [DATA_W-1:0] w_cur_sel;
  logic [DATA_W-1:0] w_tgt_sel;
  logic [DATA_W-1:0] w_new_cur;

  led_seq_tick u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (r_enable),
    .period (r_period),
    .tick   (w_tick)
  );

  // CPU writes land on the sampling edge; unmapped addresses are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) r_target[i] <= '0;
      r_enable <= 1'b0;
      r_period <= '0;
`ifdef LED_SEQ_BREATHE_EN
      r_breathe <= 1'b0;
`endif
    end else if (wr_en) begin
      case (addr)
        REG_TARGET0: r_target[0] <= wr_data;
        REG_TARGET1: r_target[1] <= wr_data;
        REG_TARGET2: r_target[2] <= wr_data;
        REG_CTRL: begin
          r_enable <= wr_data[CTRL_EN_BIT];
`ifdef LED_SEQ_BREATHE_EN
          r_breathe <= wr_data[CTRL_BREATHE_BIT];
`endif
        end
        REG_PERIOD:  r_period <= wr_data;
        default: ;
      endcase
    end
  end

  // CTRL readback: unused bits read 0
  always_comb begin
    w_ctrl_rd = '0;
    w_ctrl_rd[CTRL_EN_BIT] = r_enable;
`ifdef LED_SEQ_BREATHE_EN
    w_ctrl_rd[CTRL_BREATHE_BIT] = r_breathe;
`else
    w_ctrl_rd[CTRL_BREATHE_BIT] = 1'b0;
`endif
  end

  // Read mux over pre-write register values, so a coincident write reads old data
  always_comb begin
    w_rd_mux = '0;
    case (addr)
      REG_TARGET0: w_rd_mux = r_target[0];
      REG_TARGET1: w_rd_mux = r_target[1];
      REG_TARGET2: w_rd_mux = r_target[2];
      REG_CTRL:    w_rd_mux = w_ctrl_rd;
      REG_PERIOD:  w_rd_mux = r_period;
      default:     w_rd_mux = '0;
    endcase
  end

  // Registered read response, one cycle after the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next state: ticks outside IDLE are simply not looked at
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_tick) w_next_state = ST_CH0;
      ST_CH0:  w_next_state = ST_CH1;
      ST_CH1:  w_next_state = ST_CH2;
      ST_CH2:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: strobe, channel address and busy per state
  always_comb begin
    m_wr_en  = 1'b0;
    busy     = 1'b0;
    m_addr   = '0;
    w_ch_idx = 2'd0;
    case (r_state)
      ST_CH0: begin m_wr_en = 1'b1; busy = 1'b1; m_addr = LED_CH0_ADDR; w_ch_idx = 2'd0; end
      ST_CH1: begin m_wr_en = 1'b1; busy = 1'b1; m_addr = LED_CH1_ADDR; w_ch_idx = 2'd1; end
      ST_CH2: begin m_wr_en = 1'b1; busy = 1'b1; m_addr = LED_CH2_ADDR; w_ch_idx = 2'd2; end
      default: ;
    endcase
  end

  // Select the active channel; target is read live so mid-burst writes apply
  always_comb begin
    w_cur_sel = r_cur[0];
    w_tgt_sel = r_target[0];
`ifdef LED_SEQ_BREATHE_EN
    w_dir_sel = r_dir[0];
`endif
    case (w_ch_idx)
      2'd1: begin
        w_cur_sel = r_cur[1];
        w_tgt_sel = r_target[1];
`ifdef LED_SEQ_BREATHE_EN
        w_dir_sel = r_dir[1];
`endif
      end
      2'd2: begin
        w_cur_sel = r_cur[2];
        w_tgt_sel = r_target[2];
`ifdef LED_SEQ_BREATHE_EN
        w_dir_sel = r_dir[2];
`endif
      end
      default: ;
    endcase
  end

  // Next duty for the active channel (saturating at 0 and 255)
  always_comb begin
    w_new_cur = ramp_step(w_cur_sel, w_tgt_sel);
`ifdef LED_SEQ_BREATHE_EN
    w_new_dir = w_dir_sel;
    if (r_breathe) begin
      if (!w_dir_sel) begin
        if (w_cur_sel == 8'hFF) begin
          w_new_cur = w_cur_sel;
          w_new_dir = 1'b1;
        end else begin
          w_new_cur = w_cur_sel + 8'd1;
          if (w_new_cur == 8'hFF) w_new_dir = 1'b1;
        end
      end else begin
        if (w_cur_sel < w_tgt_sel) begin
          w_new_cur = w_cur_sel + 8'd1;
          w_new_dir = 1'b0;
        end else if (w_cur_sel == w_tgt_sel) begin
          w_new_cur = w_cur_sel;
          w_new_dir = 1'b0;
        end else begin
          w_new_cur = w_cur_sel - 8'd1;
          if (w_new_cur == w_tgt_sel) w_new_dir = 1'b0;
        end
      end
    end
`endif
  end

  assign m_wr_data = m_wr_en ? w_new_cur : '0;

  // Commit the stepped duty (and direction) of the channel being written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) r_cur[i] <= '0;
`ifdef LED_SEQ_BREATHE_EN
      for (int i = 0; i < 3; i++) r_dir[i] <= 1'b0;
`endif
    end else if (m_wr_en) begin
      case (w_ch_idx)
        2'd1: r_cur[1] <= w_new_cur;
        2'd2: r_cur[2] <= w_new_cur;
        default: r_cur[0] <= w_new_cur;
      endcase
`ifdef LED_SEQ_BREATHE_EN
      case (w_ch_idx)
        2'd1: r_dir[1] <= w_new_dir;
        2'd2: r_dir[2] <= w_new_dir;
        default: r_dir[0] <= w_new_dir;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq (default build, breathe feature disabled).
module tb_led_seq;

  logic       clk;
  logic       rst;
  logic       rd_en;
  logic [4:0] addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       m_wr_en;
  logic [4:0] m_addr;
  logic [7:0] m_wr_data;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  led_seq dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .addr      (addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .m_wr_en   (m_wr_en),
    .m_addr    (m_addr),
    .m_wr_data (m_wr_data),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: entered and left at a negedge
  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [4:0] a, input logic [7:0] exp);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, exp);
    @(negedge clk);
    check({tag, "_valid_drop"}, rd_valid, 0);
  endtask

  // wait for the next burst start; n = negedges waited
  task automatic wait_burst(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (m_wr_en) break;
    end
    if (!m_wr_en) check("burst_timeout", 0, 1);
  endtask

  // called at CH0 negedge; ends at the following IDLE negedge
  task automatic burst_check(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2);
    check({tag, "_ch0_en"}, m_wr_en, 1);
    check({tag, "_ch0_busy"}, busy, 1);
    check({tag, "_ch0_addr"}, m_addr, 0);
    check({tag, "_ch0_data"}, m_wr_data, d0);
    @(negedge clk);
    check({tag, "_ch1_addr"}, m_addr, 4);
    check({tag, "_ch1_data"}, m_wr_data, d1);
    @(negedge clk);
    check({tag, "_ch2_addr"}, m_addr, 8);
    check({tag, "_ch2_data"}, m_wr_data, d2);
    @(negedge clk);
    check({tag, "_idle_en"}, m_wr_en, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    int n;
    int strobes;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst_m_wr_en", m_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wr_data", m_wr_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    cpu_read("rd_ctrl_rst", 5'd12, 8'h00);

    // ramp up on channel 0, target 3, period 0
    cpu_write(5'd0, 8'd3);
    cpu_write(5'd16, 8'd0);
    cpu_write(5'd12, 8'h03);
    cpu_read("rd_ctrl_bit1", 5'd12, 8'h01);
    cpu_read("rd_target0", 5'd0, 8'd3);

    wait_burst(400, n);
    burst_check("b1", 8'd1, 8'd0, 8'd0);
    wait_burst(400, n);
    check("tick_interval", n, 253);
    burst_check("b2", 8'd2, 8'd0, 8'd0);
    wait_burst(400, n);
    burst_check("b3", 8'd3, 8'd0, 8'd0);
    wait_burst(400, n);
    burst_check("b4_hold", 8'd3, 8'd0, 8'd0);

    // ramp down
    cpu_write(5'd0, 8'd1);
    wait_burst(400, n);
    burst_check("b5_down", 8'd2, 8'd0, 8'd0);

    // TARGET1 written during CH0 applies to CH1 of the same burst
    wait_burst(400, n);
    check("b6_ch0_addr", m_addr, 0);
    check("b6_ch0_data", m_wr_data, 1);
    cpu_write(5'd4, 8'd5);
    check("b6_ch1_addr", m_addr, 4);
    check("b6_ch1_data", m_wr_data, 1);
    @(negedge clk);
    check("b6_ch2_data", m_wr_data, 0);
    @(negedge clk);
    check("b6_idle_busy", busy, 0);

    // clear enable during CH1: CH2 still written, then silence
    wait_burst(400, n);
    check("b7_ch0_data", m_wr_data, 1);
    @(negedge clk);
    check("b7_ch1_data", m_wr_data, 2);
    cpu_write(5'd12, 8'h00);
    check("b7_ch2_en", m_wr_en, 1);
    check("b7_ch2_addr", m_addr, 8);
    @(negedge clk);
    check("b7_idle_busy", busy, 0);
    check("b7_idle_en", m_wr_en, 0);
    strobes = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (m_wr_en) strobes++;
    end
    check("disabled_strobes", strobes, 0);

    // reset during CH0
    cpu_write(5'd12, 8'h01);
    wait_burst(400, n);
    check("pre_rst_ch0", m_addr, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_m_wr_en", m_wr_en, 0);
    check("midrst_busy", busy, 0);
    cpu_read("midrst_t0", 5'd0, 8'd0);
    cpu_read("midrst_t1", 5'd4, 8'd0);
    cpu_read("midrst_t2", 5'd8, 8'd0);
    cpu_read("midrst_ctrl", 5'd12, 8'd0);

    // coincident read and write returns the old value
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd8; wr_data = 8'd7;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("coinc_valid", rd_valid, 1);
    check("coinc_old", rd_data, 0);
    cpu_read("coinc_new", 5'd8, 8'd7);

    // unmapped addresses
    cpu_write(5'd20, 8'hFF);
    cpu_read("unmapped20", 5'd20, 8'd0);
    cpu_read("unmapped2", 5'd2, 8'd0);
    cpu_write(5'd16, 8'h5A);
    cpu_read("rd_period", 5'd16, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rd_en  input  1  CPU read strobe, one cycle.
REQ-005 addr  input  5  CPU register byte address.
REQ-006 rd_data  output  8  CPU read data.
REQ-007 rd_valid  output  1  read data valid, one cycle.
REQ-008 wr_en  input  1  CPU write strobe, one cycle.
REQ-009 wr_data  input  8  CPU write data.
REQ-010 m_wr_en  output  1  write strobe to LED PWM peripheral.
REQ-011 m_addr  output  5  LED channel address: 0, 4 or 8.
REQ-012 m_wr_data  output  8  duty value for that channel.
REQ-013 busy  output  1  high while an update burst is in progress.

Function
REQ-014 CPU register map SHALL be: 0 TARGET0, 4 TARGET1, 8 TARGET2, 12 CTRL (bit0 enable, bit1 breathe), 16 PERIOD; CPU writes to other addresses SHALL be ignored.
REQ-015 A CPU read SHALL return data with rd_valid high exactly one cycle after rd_en; unmapped addresses and unused CTRL bits SHALL read 0.
REQ-016 A CPU write SHALL take effect on the rising edge where wr_en is sampled; if rd_en and wr_en coincide on one address, the read SHALL return the old value.
REQ-017 Prescaler: 16-bit counter; a tick SHALL fire when it reaches {PERIOD,8'hFF}, then reload 0; PERIOD=0 gives a tick every 256 cycles.
REQ-018 Prescaler SHALL count only while enable=1 and SHALL be held at 0 while enable=0.
REQ-019 FSM states IDLE, CH0, CH1, CH2; a tick in IDLE SHALL move to CH0; CH0->CH1->CH2->IDLE unconditionally, one cycle each.
REQ-020 In CHn: cur[n] SHALL step one count toward the target (mode-dependent), and m_wr_en=1, m_addr=4n, m_wr_data=new cur[n] in the same cycle.
REQ-021 Ramp mode (breathe=0): cur<target -> +1; cur>target -> -1; cur==target -> unchanged but still written.
REQ-022 Breathe mode: per-channel direction bit; up: +1 until 255, then dir flips to down; down: -1 until TARGETn (floor), then dir flips to up; if cur<floor while down, step +1 and set dir=up.
REQ-023 Arithmetic SHALL be 8-bit unsigned and never wrap (0 and 255 are hard limits).
REQ-024 A tick arriving while not IDLE SHALL be dropped (not queued).
REQ-025 Clearing enable mid-burst SHALL let the burst finish to IDLE; no new bursts SHALL start.
REQ-026 busy SHALL be 1 in CH0..CH2, 0 in IDLE; m_wr_en SHALL be 0 outside CHn.
REQ-027 TARGET writes mid-burst SHALL be used by any channel not yet updated in that burst.

Reset
REQ-028 On rst: state=IDLE, prescaler=0, cur[0..2]=0, dir=up, TARGETn=0, CTRL=0, PERIOD=0, rd_data=0, rd_valid=0, m_wr_en=0, m_addr=0, m_wr_data=0, busy=0.
REQ-029 rst mid-burst SHALL abort it; m_wr_en SHALL be 0 in the cycle after rst is sampled.

Configuration
REQ-030 Macro LED_SEQ_BREATHE_EN: when defined, REQ-022 is implemented and CTRL bit1 is read/write.
REQ-031 When undefined, CTRL bit1 SHALL read 0, writes to it ignored, dir state omitted; ramp mode only.

Structure
REQ-032 Shared package SHALL hold register address constants (0,4,8,12,16), LED channel address constants, CTRL bit indices and the FSM state enum.
REQ-033 The prescaler SHALL be a sub-module led_seq_tick (inputs clk, rst, enable, period; output tick pulse).

Verification
REQ-034 Reset then read addr 12 -> rd_data=0, rd_valid one cycle after rd_en.
REQ-035 TARGET0=3, PERIOD=0, enable=1 -> writes to addr 0 with data 1,2,3,3 on successive ticks 256 cycles apart; addr 4/8 receive 0.
REQ-036 Breathe (macro defined), TARGET1=253 -> addr 4 data sequence ...,253,254,255,254,253,254 after reaching floor.
REQ-037 Macro undefined, write CTRL=8'h03 -> read returns 8'h01; ramp behaviour only.
REQ-038 Clear enable during CH1 -> CH2 write still issued, busy falls, no further m_wr_en for 2048 cycles.
REQ-039 Assert rst during CH0 -> next cycle m_wr_en=0, busy=0, reads of TARGET0..2 return 0.
